// File: rtl/cam_alloc_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the tag CAM allocation controller.
package cam_alloc_ctrl_pkg;

    localparam int CAM_DEPTH   = 16;
    localparam int CAM_INDEX   = 4;
    localparam int CAM_WIDTH   = 8;
    localparam int ALLOC_PORTS = 4;

    localparam logic [CAM_WIDTH-1:0] SCRUB_TAG = '0;

    // One scrub cycle rewrites ALLOC_PORTS consecutive entries.
    localparam int SCRUB_CYCLES = CAM_DEPTH / ALLOC_PORTS;
    localparam int SCRUB_CNT_W  = CAM_INDEX - 2;

    typedef enum logic {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Number of set bits in a CAM-wide mask.
    function automatic logic [CAM_INDEX:0] popcount(input logic [CAM_DEPTH-1:0] v);
        logic [CAM_INDEX:0] c;
        c = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            c = c + {{CAM_INDEX{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/cam_alloc_ctrl_free_pick4.sv
// Combinational picker: hands the k-th lowest free entry to the k-th requesting port.
module free_pick4
    import cam_alloc_ctrl_pkg::*;
#(
    parameter int DEPTH = CAM_DEPTH,
    parameter int INDEX = CAM_INDEX
) (
    input  logic [DEPTH-1:0]             free_mask,
    input  logic [ALLOC_PORTS-1:0]       req,
    output logic [ALLOC_PORTS-1:0]       gnt,
    output logic [ALLOC_PORTS*INDEX-1:0] addr
);

    logic [DEPTH-1:0] avail;
    logic             found;

    // Cascaded find-first-set; each grant removes its entry before the next port looks.
    always_comb begin
        avail = free_mask;
        gnt   = '0;
        addr  = '0;
        found = 1'b0;
        for (int k = 0; k < ALLOC_PORTS; k++) begin
            found = 1'b0;
            if (req[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!found && avail[i]) begin
                        found                  = 1'b1;
                        addr[k*INDEX +: INDEX] = INDEX'(i);
                        avail[i]               = 1'b0;
                    end
                end
            end
            gnt[k] = found;
        end
    end

endmodule

// File: rtl/cam_alloc_ctrl.sv
// Allocation and write-port scheduler for a 16-entry, 4-write-port tag CAM.
module cam_alloc_ctrl
    import cam_alloc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 allocReq0_i,
    input  logic                 allocReq1_i,
    input  logic                 allocReq2_i,
    input  logic                 allocReq3_i,
    input  logic [CAM_WIDTH-1:0] allocTag0_i,
    input  logic [CAM_WIDTH-1:0] allocTag1_i,
    input  logic [CAM_WIDTH-1:0] allocTag2_i,
    input  logic [CAM_WIDTH-1:0] allocTag3_i,
    input  logic [CAM_DEPTH-1:0] release_i,
    input  logic                 flush_i,
    output logic                 allocGnt0_o,
    output logic                 allocGnt1_o,
    output logic                 allocGnt2_o,
    output logic                 allocGnt3_o,
    output logic [CAM_INDEX-1:0] allocAddr0_o,
    output logic [CAM_INDEX-1:0] allocAddr1_o,
    output logic [CAM_INDEX-1:0] allocAddr2_o,
    output logic [CAM_INDEX-1:0] allocAddr3_o,
    output logic                 we0_o,
    output logic                 we1_o,
    output logic                 we2_o,
    output logic                 we3_o,
    output logic [CAM_INDEX-1:0] addr0wr_o,
    output logic [CAM_INDEX-1:0] addr1wr_o,
    output logic [CAM_INDEX-1:0] addr2wr_o,
    output logic [CAM_INDEX-1:0] addr3wr_o,
    output logic [CAM_WIDTH-1:0] tag0wr_o,
    output logic [CAM_WIDTH-1:0] tag1wr_o,
    output logic [CAM_WIDTH-1:0] tag2wr_o,
    output logic [CAM_WIDTH-1:0] tag3wr_o,
    output logic [CAM_DEPTH-1:0] valid_o,
    output logic [CAM_INDEX:0]   freeCnt_o,
    output logic                 full_o,
    output logic                 busy_o
);

    localparam logic [SCRUB_CNT_W-1:0] SCRUB_LAST = SCRUB_CNT_W'(SCRUB_CYCLES - 1);
    localparam logic [CAM_INDEX:0]     FREE_ALL   = (CAM_INDEX+1)'(CAM_DEPTH);

    state_t                           state, state_next;
    logic [SCRUB_CNT_W-1:0]           scrub_cnt, scrub_cnt_next;
    logic [CAM_DEPTH-1:0]             valid_q, valid_next;
    logic [CAM_INDEX:0]               free_cnt, free_cnt_next;
    logic                             alloc_en;
    logic [ALLOC_PORTS-1:0]           req_vec, gnt;
    logic [ALLOC_PORTS*CAM_INDEX-1:0] pick_addr;
    logic [ALLOC_PORTS*CAM_WIDTH-1:0] tag_vec;
    logic [CAM_DEPTH-1:0]             alloc_set, release_eff;
    logic [ALLOC_PORTS-1:0]           we_vec;
    logic [ALLOC_PORTS*CAM_INDEX-1:0] wr_addr;
    logic [ALLOC_PORTS*CAM_WIDTH-1:0] wr_tag;

    // Flush wins over allocation, and nothing is granted while scrubbing.
    assign alloc_en    = (state == RUN) && !flush_i;
    assign req_vec     = {allocReq3_i, allocReq2_i, allocReq1_i, allocReq0_i} & {ALLOC_PORTS{alloc_en}};
    assign tag_vec     = {allocTag3_i, allocTag2_i, allocTag1_i, allocTag0_i};
    assign release_eff = release_i & valid_q;

    free_pick4 #(
        .DEPTH (CAM_DEPTH),
        .INDEX (CAM_INDEX)
    ) u_pick (
        .free_mask (~valid_q),
        .req       (req_vec),
        .gnt       (gnt),
        .addr      (pick_addr)
    );

    // Decode the granted addresses into a bitmap of entries becoming valid.
    always_comb begin
        alloc_set = '0;
        for (int k = 0; k < ALLOC_PORTS; k++) begin
            if (gnt[k]) begin
                alloc_set[pick_addr[k*CAM_INDEX +: CAM_INDEX]] = 1'b1;
            end
        end
    end

    // State, scrub position, valid bitmap and free count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCRUB;
            scrub_cnt <= '0;
            valid_q   <= '0;
            free_cnt  <= FREE_ALL;
        end else begin
            state     <= state_next;
            scrub_cnt <= scrub_cnt_next;
            valid_q   <= valid_next;
            free_cnt  <= free_cnt_next;
        end
    end

    // Next-state: walk the scrub, then allocate/release until a flush restarts it.
    always_comb begin
        state_next     = state;
        scrub_cnt_next = scrub_cnt;
        valid_next     = valid_q;
        free_cnt_next  = free_cnt;
        case (state)
            SCRUB: begin
                if (scrub_cnt == SCRUB_LAST) begin
                    state_next     = RUN;
                    scrub_cnt_next = '0;
                end else begin
                    scrub_cnt_next = scrub_cnt + 1'b1;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_next     = SCRUB;
                    scrub_cnt_next = '0;
                    valid_next     = '0;
                    free_cnt_next  = FREE_ALL;
                end else begin
                    valid_next    = (valid_q & ~release_eff) | alloc_set;
                    free_cnt_next = free_cnt
                                  - popcount({{(CAM_DEPTH-ALLOC_PORTS){1'b0}}, gnt})
                                  + popcount(release_eff);
                end
            end
            default: begin
                state_next = SCRUB;
            end
        endcase
    end

    // CAM write ports: scrub sweeps four entries per cycle, RUN mirrors the grants.
    always_comb begin
        we_vec  = '0;
        wr_addr = '0;
        wr_tag  = '0;
        if (reset) begin
            case (state)
                SCRUB: begin
                    for (int k = 0; k < ALLOC_PORTS; k++) begin
                        we_vec[k]                          = 1'b1;
                        wr_addr[k*CAM_INDEX +: CAM_INDEX]  = {scrub_cnt, 2'(k)};
                        wr_tag[k*CAM_WIDTH +: CAM_WIDTH]   = SCRUB_TAG;
                    end
                end
                RUN: begin
                    for (int k = 0; k < ALLOC_PORTS; k++) begin
                        if (gnt[k]) begin
                            we_vec[k]                         = 1'b1;
                            wr_addr[k*CAM_INDEX +: CAM_INDEX] = pick_addr[k*CAM_INDEX +: CAM_INDEX];
                            wr_tag[k*CAM_WIDTH +: CAM_WIDTH]  = tag_vec[k*CAM_WIDTH +: CAM_WIDTH];
                        end
                    end
                end
                default: begin
                    we_vec = '0;
                end
            endcase
        end
    end

    assign {allocGnt3_o, allocGnt2_o, allocGnt1_o, allocGnt0_o}     = gnt;
    assign {allocAddr3_o, allocAddr2_o, allocAddr1_o, allocAddr0_o} = pick_addr;
    assign {we3_o, we2_o, we1_o, we0_o}                             = we_vec;
    assign {addr3wr_o, addr2wr_o, addr1wr_o, addr0wr_o}             = wr_addr;
    assign {tag3wr_o, tag2wr_o, tag1wr_o, tag0wr_o}                 = wr_tag;
    assign valid_o   = valid_q;
    assign freeCnt_o = free_cnt;
    assign full_o    = (free_cnt == '0);
    assign busy_o    = (state == SCRUB);

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Scoreboard bench for cam_alloc_ctrl: stimulus queues expected cycles, monitor compares.
module tb_cam_alloc_ctrl;

    typedef struct {
        logic [3:0]  gnt;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] tag;
        logic [15:0] valid;
        logic [4:0]  freeCnt;
        logic        busy;
    } expT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        allocReq0_i = 1'b0, allocReq1_i = 1'b0, allocReq2_i = 1'b0, allocReq3_i = 1'b0;
    logic [7:0]  allocTag0_i = '0, allocTag1_i = '0, allocTag2_i = '0, allocTag3_i = '0;
    logic [15:0] release_i = '0;
    logic        flush_i = 1'b0;
    logic        allocGnt0_o, allocGnt1_o, allocGnt2_o, allocGnt3_o;
    logic [3:0]  allocAddr0_o, allocAddr1_o, allocAddr2_o, allocAddr3_o;
    logic        we0_o, we1_o, we2_o, we3_o;
    logic [3:0]  addr0wr_o, addr1wr_o, addr2wr_o, addr3wr_o;
    logic [7:0]  tag0wr_o, tag1wr_o, tag2wr_o, tag3wr_o;
    logic [15:0] valid_o;
    logic [4:0]  freeCnt_o;
    logic        full_o, busy_o;

    expT expQ[$];
    int  checks = 0;
    int  failures = 0;
    int  cycIdx = 0;
    bit  monEn = 1'b0;

    cam_alloc_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .allocReq0_i  (allocReq0_i),
        .allocReq1_i  (allocReq1_i),
        .allocReq2_i  (allocReq2_i),
        .allocReq3_i  (allocReq3_i),
        .allocTag0_i  (allocTag0_i),
        .allocTag1_i  (allocTag1_i),
        .allocTag2_i  (allocTag2_i),
        .allocTag3_i  (allocTag3_i),
        .release_i    (release_i),
        .flush_i      (flush_i),
        .allocGnt0_o  (allocGnt0_o),
        .allocGnt1_o  (allocGnt1_o),
        .allocGnt2_o  (allocGnt2_o),
        .allocGnt3_o  (allocGnt3_o),
        .allocAddr0_o (allocAddr0_o),
        .allocAddr1_o (allocAddr1_o),
        .allocAddr2_o (allocAddr2_o),
        .allocAddr3_o (allocAddr3_o),
        .we0_o        (we0_o),
        .we1_o        (we1_o),
        .we2_o        (we2_o),
        .we3_o        (we3_o),
        .addr0wr_o    (addr0wr_o),
        .addr1wr_o    (addr1wr_o),
        .addr2wr_o    (addr2wr_o),
        .addr3wr_o    (addr3wr_o),
        .tag0wr_o     (tag0wr_o),
        .tag1wr_o     (tag1wr_o),
        .tag2wr_o     (tag2wr_o),
        .tag3wr_o     (tag3wr_o),
        .valid_o      (valid_o),
        .freeCnt_o    (freeCnt_o),
        .full_o       (full_o),
        .busy_o       (busy_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Single comparison with failure reporting.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h", name, cycIdx, act, exp);
        end
    endtask

    // Compare every observable output of one cycle against its queued expectation.
    task automatic checkOutput(input expT e);
        logic [3:0]  actWe, actGnt;
        logic [15:0] actWrAddr, actAllocAddr, expAllocAddr, expWrAddr;
        logic [31:0] actTag, expTag;
        actWe        = {we3_o, we2_o, we1_o, we0_o};
        actGnt       = {allocGnt3_o, allocGnt2_o, allocGnt1_o, allocGnt0_o};
        actWrAddr    = {addr3wr_o, addr2wr_o, addr1wr_o, addr0wr_o};
        actAllocAddr = {allocAddr3_o, allocAddr2_o, allocAddr1_o, allocAddr0_o};
        actTag       = {tag3wr_o, tag2wr_o, tag1wr_o, tag0wr_o};
        expWrAddr    = '0;
        expAllocAddr = '0;
        expTag       = '0;
        for (int k = 0; k < 4; k++) begin
            if (!actWe[k]) begin
                actWrAddr[k*4 +: 4] = '0;
                actTag[k*8 +: 8]    = '0;
            end
            if (!actGnt[k]) actAllocAddr[k*4 +: 4] = '0;
            if (e.we[k]) begin
                expWrAddr[k*4 +: 4] = e.addr[k*4 +: 4];
                expTag[k*8 +: 8]    = e.tag[k*8 +: 8];
            end
            if (e.gnt[k]) expAllocAddr[k*4 +: 4] = e.addr[k*4 +: 4];
        end
        checkVal("gnt",       {28'd0, actGnt},       {28'd0, e.gnt});
        checkVal("we",        {28'd0, actWe},        {28'd0, e.we});
        checkVal("wr_addr",   {16'd0, actWrAddr},    {16'd0, expWrAddr});
        checkVal("wr_tag",    actTag,                expTag);
        checkVal("alloc_addr",{16'd0, actAllocAddr}, {16'd0, expAllocAddr});
        checkVal("valid",     {16'd0, valid_o},      {16'd0, e.valid});
        checkVal("free_cnt",  {27'd0, freeCnt_o},    {27'd0, e.freeCnt});
        checkVal("full",      {31'd0, full_o},       {31'd0, (e.freeCnt == 5'd0)});
        checkVal("busy",      {31'd0, busy_o},       {31'd0, e.busy});
    endtask

    // Drive one cycle of inputs just after the edge and queue what that cycle must show.
    task automatic applyStimulus(input logic rstN, input logic [3:0] req, input logic [31:0] tags,
                                 input logic [15:0] rel, input logic fl,
                                 input logic [3:0] eGnt, input logic [3:0] eWe,
                                 input logic [15:0] eAddr, input logic [31:0] eTag,
                                 input logic [15:0] eValid, input logic [4:0] eFree, input logic eBusy);
        expT e;
        @(posedge clk);
        #1;
        reset = rstN;
        {allocReq3_i, allocReq2_i, allocReq1_i, allocReq0_i} = req;
        {allocTag3_i, allocTag2_i, allocTag1_i, allocTag0_i} = tags;
        release_i = rel;
        flush_i   = fl;
        e.gnt = eGnt; e.we = eWe; e.addr = eAddr; e.tag = eTag;
        e.valid = eValid; e.freeCnt = eFree; e.busy = eBusy;
        expQ.push_back(e);
    endtask

    // Monitor: pop one expectation per cycle and compare on the falling edge.
    always @(negedge clk) begin
        if (monEn) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL queue_empty cyc=%0d actual=0 expected=1", cycIdx);
            end else begin
                checkOutput(expQ.pop_front());
            end
            cycIdx++;
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        //             rst req    tags          release   fl  gnt   we    addr      tag           valid     free  busy
        applyStimulus(0, 4'h0, 32'h0,        16'h0000, 0, 4'h0, 4'h0, 16'h0000, 32'h0,        16'h0000, 5'd16, 1);
        monEn = 1'b1;
        applyStimulus(1, 4'h0, 32'h0,        16'h0000, 0, 4'h0, 4'hF, 16'h3210, 32'h0,        16'h0000, 5'd16, 1);
        applyStimulus(1, 4'hF, 32'h55555555, 16'hFFFF, 0, 4'h0, 4'hF, 16'h7654, 32'h0,        16'h0000, 5'd16, 1);
        applyStimulus(1, 4'h0, 32'h0,        16'h0000, 1, 4'h0, 4'hF, 16'hBA98, 32'h0,        16'h0000, 5'd16, 1);
        applyStimulus(1, 4'h0, 32'h0,        16'h0000, 0, 4'h0, 4'hF, 16'hFEDC, 32'h0,        16'h0000, 5'd16, 1);
        applyStimulus(1, 4'hF, 32'hA4A3A2A1, 16'h0000, 0, 4'hF, 4'hF, 16'h3210, 32'hA4A3A2A1, 16'h0000, 5'd16, 0);
        applyStimulus(1, 4'h0, 32'h0,        16'h000A, 0, 4'h0, 4'h0, 16'h0000, 32'h0,        16'h000F, 5'd12, 0);
        applyStimulus(1, 4'hA, 32'hB3B2B1B0, 16'h0101, 0, 4'hA, 4'hA, 16'h3010, 32'hB300B100, 16'h0005, 5'd14, 0);
        applyStimulus(1, 4'hF, 32'hC3C2C1C0, 16'h0000, 0, 4'hF, 4'hF, 16'h6540, 32'hC3C2C1C0, 16'h000E, 5'd13, 0);
        applyStimulus(1, 4'hF, 32'hD3D2D1D0, 16'h0000, 0, 4'hF, 4'hF, 16'hA987, 32'hD3D2D1D0, 16'h007F, 5'd9,  0);
        applyStimulus(1, 4'h7, 32'hE3E2E1E0, 16'h0000, 0, 4'h7, 4'h7, 16'h0DCB, 32'h00E2E1E0, 16'h07FF, 5'd5,  0);
        applyStimulus(1, 4'hF, 32'hF3F2F1F0, 16'h0000, 0, 4'h3, 4'h3, 16'h00FE, 32'h0000F1F0, 16'h3FFF, 5'd2,  0);
        applyStimulus(1, 4'hF, 32'h12345678, 16'h0011, 0, 4'h0, 4'h0, 16'h0000, 32'h0,        16'hFFFF, 5'd0,  0);
        applyStimulus(1, 4'hF, 32'h11223344, 16'h0000, 0, 4'h3, 4'h3, 16'h0040, 32'h00003344, 16'hFFEE, 5'd2,  0);
        applyStimulus(1, 4'h0, 32'h0,        16'hFF00, 0, 4'h0, 4'h0, 16'h0000, 32'h0,        16'hFFFF, 5'd0,  0);
        applyStimulus(1, 4'h3, 32'h66778899, 16'h0000, 1, 4'h0, 4'h0, 16'h0000, 32'h0,        16'h00FF, 5'd8,  0);
        applyStimulus(1, 4'h0, 32'h0,        16'h0000, 0, 4'h0, 4'hF, 16'h3210, 32'h0,        16'h0000, 5'd16, 1);
        applyStimulus(1, 4'h0, 32'h0,        16'h0000, 0, 4'h0, 4'hF, 16'h7654, 32'h0,        16'h0000, 5'd16, 1);
        applyStimulus(0, 4'h0, 32'h0,        16'h0000, 0, 4'h0, 4'h0, 16'h0000, 32'h0,        16'h0000, 5'd16, 1);
        applyStimulus(1, 4'h0, 32'h0,        16'h0000, 0, 4'h0, 4'hF, 16'h3210, 32'h0,        16'h0000, 5'd16, 1);
        applyStimulus(1, 4'h0, 32'h0,        16'h0000, 0, 4'h0, 4'hF, 16'h7654, 32'h0,        16'h0000, 5'd16, 1);
        applyStimulus(1, 4'h0, 32'h0,        16'h0000, 0, 4'h0, 4'hF, 16'hBA98, 32'h0,        16'h0000, 5'd16, 1);
        applyStimulus(1, 4'h0, 32'h0,        16'h0000, 0, 4'h0, 4'hF, 16'hFEDC, 32'h0,        16'h0000, 5'd16, 1);
        applyStimulus(1, 4'hF, 32'hA4A3A2A1, 16'h0000, 0, 4'hF, 4'hF, 16'h3210, 32'hA4A3A2A1, 16'h0000, 5'd16, 0);
        applyStimulus(1, 4'h0, 32'h0,        16'h0000, 0, 4'h0, 4'h0, 16'h0000, 32'h0,        16'h000F, 5'd12, 0);
        @(negedge clk);
        #1;
        monEn = 1'b0;
        checkVal("queue_drained", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
